// File: rtl/game_pkg.sv
// Shared definitions for the game-round controller: state encoding, LFSR constants, counter width.
package game_pkg;

    localparam int unsigned CNT_W = 5;
    localparam int unsigned PAT_W = 8;
    localparam logic [PAT_W-1:0] DEFAULT_SEED = 8'hA5;
    // Feedback taps at bits 7,5,4,3
    localparam logic [PAT_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WINDOW = 3'd3,
        S_GAP    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    function automatic logic [PAT_W-1:0] lfsr_next(input logic [PAT_W-1:0] v);
        return {v[PAT_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock into a one-cycle tick every TICK_DIV cycles, restartable by a sync clear.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 1000000
) (
    input  logic clock100m,
    input  logic reset,
    input  logic clear,
    output logic tick_c
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0] count;

    assign tick_c = (count == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clock100m or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || tick_c) begin
            count <= '0;
        end else begin
            count <= count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/pattern_scheduler.sv
// Game-round controller: clears the score, issues one LFSR target per round, times the
// response window and inter-round gap, and tallies hits and misses.
module pattern_scheduler
    import game_pkg::*;
#(
    parameter int unsigned ROUNDS       = 16,
    parameter int unsigned TICK_DIV     = 1000000,
    parameter int unsigned WINDOW_TICKS = 50,
    parameter int unsigned GAP_TICKS    = 20
) (
    input  logic             clock100m,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] seed,
    input  logic [PAT_W-1:0] calc_pattern,
    output logic [PAT_W-1:0] pattern,
    output logic             score_clear,
    output logic [CNT_W-1:0] round_idx,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic             busy,
    output logic             done
);

    localparam int unsigned TICK_MAX = (WINDOW_TICKS > GAP_TICKS) ? WINDOW_TICKS : GAP_TICKS;
    localparam int unsigned TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX + 1) : 1;

    state_t            state;
    logic [PAT_W-1:0]  lfsr;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick_c;
    logic              hit_c;
    logic              prescale_clear_c;

    assign hit_c = (calc_pattern == '0);

    // Prescaler restarts from zero on every WINDOW/GAP entry, including an early hit exit
    assign prescale_clear_c = !((state == S_WINDOW) || (state == S_GAP))
                            || ((state == S_WINDOW) && hit_c);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clock100m (clock100m),
        .reset     (reset),
        .clear     (prescale_clear_c),
        .tick_c    (tick_c)
    );

    always_ff @(posedge clock100m or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            lfsr        <= DEFAULT_SEED;
            tick_cnt    <= '0;
            pattern     <= '0;
            score_clear <= 1'b0;
            round_idx   <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            pattern     <= '0;
            score_clear <= 1'b0;
            done        <= 1'b0;
            if (abort && (state != S_IDLE)) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state       <= S_CLEAR;
                            busy        <= 1'b1;
                            score_clear <= 1'b1;
                            lfsr        <= (seed == '0) ? DEFAULT_SEED : seed;
                            round_idx   <= '0;
                            hit_count   <= '0;
                            miss_count  <= '0;
                        end
                    end
                    S_CLEAR: begin
                        state   <= S_ISSUE;
                        pattern <= lfsr;
                    end
                    S_ISSUE: begin
                        state    <= S_WINDOW;
                        tick_cnt <= '0;
                    end
                    // A hit wins over a coincident timeout
                    S_WINDOW: begin
                        if (hit_c) begin
                            hit_count <= hit_count + CNT_W'(1);
                            tick_cnt  <= '0;
                            state     <= S_GAP;
                        end else if (tick_c) begin
                            if (tick_cnt == TICK_W'(WINDOW_TICKS - 1)) begin
                                miss_count <= miss_count + CNT_W'(1);
                                tick_cnt   <= '0;
                                state      <= S_GAP;
                            end else begin
                                tick_cnt <= tick_cnt + TICK_W'(1);
                            end
                        end
                    end
                    S_GAP: begin
                        if (tick_c) begin
                            if (tick_cnt == TICK_W'(GAP_TICKS - 1)) begin
                                tick_cnt <= '0;
                                lfsr     <= lfsr_next(lfsr);
                                if (round_idx == CNT_W'(ROUNDS - 1)) begin
                                    state <= S_DONE;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                end else begin
                                    state     <= S_ISSUE;
                                    pattern   <= lfsr_next(lfsr);
                                    round_idx <= round_idx + CNT_W'(1);
                                end
                            end else begin
                                tick_cnt <= tick_cnt + TICK_W'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pattern_scheduler.sv
// Directed bench for pattern_scheduler with short timing parameters and a registered calculator model.
module tb_pattern_scheduler;

    logic       clock100m;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] seed;
    logic [7:0] calc_pattern;
    logic [7:0] pattern;
    logic       score_clear;
    logic [4:0] round_idx;
    logic [4:0] hit_count;
    logic [4:0] miss_count;
    logic       busy;
    logic       done;
    logic       hit_req;

    int checks = 0;
    int passes = 0;
    int done_pulses = 0;

    pattern_scheduler #(
        .ROUNDS       (3),
        .TICK_DIV     (4),
        .WINDOW_TICKS (3),
        .GAP_TICKS    (2)
    ) dut (
        .clock100m    (clock100m),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .seed         (seed),
        .calc_pattern (calc_pattern),
        .pattern      (pattern),
        .score_clear  (score_clear),
        .round_idx    (round_idx),
        .hit_count    (hit_count),
        .miss_count   (miss_count),
        .busy         (busy),
        .done         (done)
    );

    initial clock100m = 1'b0;
    always #5 clock100m = ~clock100m;

    // Score calculator stand-in: clear on score_clear, load on pattern, drop to 0 on a player hit
    always_ff @(posedge clock100m or negedge reset) begin
        if (!reset)                calc_pattern <= 8'h00;
        else if (score_clear)      calc_pattern <= 8'h00;
        else if (pattern != 8'h00) calc_pattern <= pattern;
        else if (hit_req)          calc_pattern <= 8'h00;
    end

    always @(posedge clock100m) if (done) done_pulses++;

    task automatic step(input int n);
        repeat (n) @(posedge clock100m);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; seed = 8'h00; hit_req = 1'b0;
        #3;
        check("rst_pattern", 32'(pattern), 32'h0);
        check("rst_score_clear", 32'(score_clear), 32'h0);
        check("rst_round", 32'(round_idx), 32'h0);
        check("rst_hit", 32'(hit_count), 32'h0);
        check("rst_miss", 32'(miss_count), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        step(2);
        reset = 1'b1;
        step(1);

        // Game 1, round 0: hit five cycles into the window
        seed = 8'h00; start = 1'b1;
        step(1); start = 1'b0;
        check("g1_score_clear", 32'(score_clear), 32'h1);
        check("g1_busy", 32'(busy), 32'h1);
        check("g1_clear_pattern", 32'(pattern), 32'h0);
        step(1);
        check("g1_pattern_a5", 32'(pattern), 32'hA5);
        check("g1_score_clear_off", 32'(score_clear), 32'h0);
        step(1);
        check("g1_pattern_one_cycle", 32'(pattern), 32'h0);
        check("g1_no_false_hit", 32'(hit_count), 32'h0);
        step(4); hit_req = 1'b1;
        step(1); hit_req = 1'b0;
        check("r0_hit_pending", 32'(hit_count), 32'h0);
        step(1);
        check("r0_hit", 32'(hit_count), 32'h1);
        check("r0_miss", 32'(miss_count), 32'h0);
        step(7);
        check("r0_gap_end_round", 32'(round_idx), 32'h0);
        check("r0_gap_end_pattern", 32'(pattern), 32'h0);
        step(1);
        check("r1_pattern_4a", 32'(pattern), 32'h4A);
        check("r1_round", 32'(round_idx), 32'h1);

        // Round 1: no hit, window is exactly 12 cycles
        step(1);
        step(11);
        check("r1_window_last", 32'(miss_count), 32'h0);
        check("r1_busy", 32'(busy), 32'h1);
        step(1);
        check("r1_miss", 32'(miss_count), 32'h1);
        check("r1_hit_hold", 32'(hit_count), 32'h1);
        step(7);
        check("r1_gap_end_round", 32'(round_idx), 32'h1);
        step(1);
        check("r2_pattern_95", 32'(pattern), 32'h95);
        check("r2_round", 32'(round_idx), 32'h2);

        // Round 2: immediate hit, then game end
        step(1); hit_req = 1'b1;
        step(1); hit_req = 1'b0;
        step(1);
        check("r2_hit", 32'(hit_count), 32'h2);
        step(7);
        check("r2_gap_no_done", 32'(done), 32'h0);
        check("r2_gap_busy", 32'(busy), 32'h1);
        step(1);
        check("end_done", 32'(done), 32'h1);
        check("end_busy", 32'(busy), 32'h0);
        check("end_hit", 32'(hit_count), 32'h2);
        check("end_miss", 32'(miss_count), 32'h1);
        check("end_round", 32'(round_idx), 32'h2);
        step(1);
        check("idle_done_off", 32'(done), 32'h0);
        check("idle_hit_hold", 32'(hit_count), 32'h2);

        // start with abort in IDLE is rejected
        start = 1'b1; abort = 1'b1;
        step(1); start = 1'b0; abort = 1'b0;
        check("startabort_busy", 32'(busy), 32'h0);
        check("startabort_clear", 32'(score_clear), 32'h0);

        // Game 2: start while busy ignored, abort mid-window
        seed = 8'h3C; start = 1'b1;
        step(1); start = 1'b0;
        check("g2_hit_cleared", 32'(hit_count), 32'h0);
        check("g2_miss_cleared", 32'(miss_count), 32'h0);
        step(1);
        check("g2_pattern_seed", 32'(pattern), 32'h3C);
        step(2);
        seed = 8'h11; start = 1'b1;
        step(1); start = 1'b0;
        check("g2_restart_ignored", 32'(score_clear), 32'h0);
        check("g2_still_busy", 32'(busy), 32'h1);
        abort = 1'b1;
        step(1); abort = 1'b0;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_pattern", 32'(pattern), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        step(20);
        check("abort_stays_idle", 32'(busy), 32'h0);
        check("abort_round_hold", 32'(round_idx), 32'h0);

        // Game 3: asynchronous reset mid-GAP, then clean restart
        seed = 8'h00; start = 1'b1;
        step(1); start = 1'b0;
        step(1);
        step(1); hit_req = 1'b1;
        step(1); hit_req = 1'b0;
        step(1);
        check("g3_gap_hit", 32'(hit_count), 32'h1);
        step(2);
        #2 reset = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'h0);
        check("async_hit", 32'(hit_count), 32'h0);
        check("async_pattern", 32'(pattern), 32'h0);
        check("async_done", 32'(done), 32'h0);
        check("async_score_clear", 32'(score_clear), 32'h0);
        check("async_round", 32'(round_idx), 32'h0);
        check("async_miss", 32'(miss_count), 32'h0);
        #2 reset = 1'b1;
        step(1);
        seed = 8'h00; start = 1'b1;
        step(1); start = 1'b0;
        check("g4_score_clear", 32'(score_clear), 32'h1);
        check("g4_busy", 32'(busy), 32'h1);
        step(1);
        check("g4_pattern_a5", 32'(pattern), 32'hA5);
        check("done_pulse_count", 32'(done_pulses), 32'h1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
